rx_bit_timer: RTL and testbench

//  Bit-timing controller for the serial receive path. Runs a clocks-per-bit counter (wraps
//  1..period) and a received-bit counter. Emits a mid-bit shift_strobe to the shift

---
 rtl/rx_bit_timer.sv | 64 ++++++
 tb/tb_rx_bit_timer.sv | 92 +++++++++
 2 files changed

// File: rtl/rx_bit_timer.sv
// rx_bit_timer: bit-timing controller for the serial receive path.
// Times each bit period, strobes the shift register mid-bit and flags end of frame.
module rx_bit_timer #(
    parameter int PERIOD_BITS   = 14,
    parameter int NUM_DATA_BITS = 9,
    parameter int BIT_CNT_BITS  = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    enable_timer,
    input  logic [PERIOD_BITS-1:0]  bit_period,
    output logic                    shift_strobe,
    output logic                    packet_done,
    output logic [BIT_CNT_BITS-1:0] bit_index,
    output logic                    busy
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam logic [BIT_CNT_BITS-1:0] LAST = BIT_CNT_BITS'(NUM_DATA_BITS);
    localparam logic [PERIOD_BITS-1:0]  MIN_P = PERIOD_BITS'(2);
    state_t                  state, state_nxt;
    logic [PERIOD_BITS-1:0]  clk_cnt, cnt_nxt, period_q, period_nxt;
    logic [BIT_CNT_BITS-1:0] idx_nxt;
    logic                    strobe_nxt;
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = clk_cnt;
        period_nxt = period_q;
        if (!enable_timer) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else if (state == IDLE) begin
            state_nxt  = RUN;
            period_nxt = (bit_period < MIN_P) ? MIN_P : bit_period;
            cnt_nxt    = PERIOD_BITS'(1);
        end else if (state == RUN) begin
            if (clk_cnt == period_q && bit_index == LAST)
                state_nxt = DONE;
            else
                cnt_nxt = (clk_cnt == period_q) ? PERIOD_BITS'(1) : clk_cnt + 1'b1;
        end
        // strobe decided from next-state values so the registered pulse lines up with clk_cnt==mid
        strobe_nxt = (state_nxt == RUN) && (cnt_nxt == (period_nxt >> 1)) && (bit_index < LAST);
        idx_nxt    = !enable_timer ? '0 : bit_index + BIT_CNT_BITS'(strobe_nxt);
    end
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state        <= IDLE;
            clk_cnt      <= '0;
            period_q     <= '0;
            bit_index    <= '0;
            shift_strobe <= 1'b0;
            packet_done  <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_nxt;
            clk_cnt      <= cnt_nxt;
            period_q     <= period_nxt;
            bit_index    <= idx_nxt;
            shift_strobe <= strobe_nxt;
            packet_done  <= (state == RUN) && (state_nxt == DONE);
            busy         <= (state_nxt == RUN);
        end
    end
endmodule

// File: tb/tb_rx_bit_timer.sv
// tb_rx_bit_timer: directed + randomized frames checked against an arithmetic timing model.
module tb_rx_bit_timer;
    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        enable_timer = 1'b0;
    logic [13:0] bit_period = '0;
    logic        shift_strobe, packet_done, busy;
    logic [3:0]  bit_index;
    int checks = 0;
    int errors = 0;

    rx_bit_timer dut (
        .clk(clk), .n_rst(n_rst), .enable_timer(enable_timer), .bit_period(bit_period),
        .shift_strobe(shift_strobe), .packet_done(packet_done), .bit_index(bit_index), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_strobe"}, 32'(shift_strobe), 0);
        chk({tag, "_done"}, 32'(packet_done), 0);
        chk({tag, "_idx"}, 32'(bit_index), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
    endtask

    // Frame of period p: strobes at k = mid + j*pe (j<9), done pulse at k = 9*pe+1.
    task automatic frame(input int p, input int len, input int abort_k);
        int pe, mid, n, e_idx;
        pe  = (p < 2) ? 2 : p;
        mid = pe / 2;
        bit_period   = 14'(p);
        enable_timer = 1'b1;
        for (int k = 1; k <= len; k++) begin
            @(posedge clk); #1;
            bit_period = 14'($urandom);
            n = (k < mid) ? 0 : (k - mid) / pe + 1;
            e_idx = (n > 9) ? 9 : n;
            chk("strobe", 32'(shift_strobe), 32'(k >= mid && (k - mid) % pe == 0 && n <= 9));
            chk("bit_index", 32'(bit_index), 32'(e_idx));
            chk("packet_done", 32'(packet_done), 32'(k == 9 * pe + 1));
            chk("busy", 32'(busy), 32'(k <= 9 * pe));
            if (k == abort_k) break;
        end
        enable_timer = 1'b0;
        @(posedge clk); #1;
        chk_idle("after_frame");
    endtask

    initial begin
        #2;
        chk_idle("reset");
        @(negedge clk);
        n_rst = 1'b1;
        @(posedge clk); #1;
        chk_idle("idle");
        frame(10, 95, 0);
        frame(2, 22, 0);
        frame(1, 22, 0);
        frame(10, 95, 37);
        frame(10, 12, 0);
        frame(20, 185, 0);
        frame(3, 9 * 3 + 51, 0);
        frame(10, 91 + 50, 0);
        frame(5, 50, 0);
        // async reset mid-frame, between clock edges
        bit_period   = 14'd10;
        enable_timer = 1'b1;
        repeat (14) @(posedge clk);
        #3 n_rst = 1'b0;
        #1 chk_idle("async_reset");
        @(negedge clk);
        n_rst = 1'b1;
        frame(7, 70, 0);
        for (int i = 0; i < 6; i++)
            frame(int'($urandom_range(1, 40)), 0, 0) ;
        for (int i = 0; i < 6; i++) begin
            int p = int'($urandom_range(1, 40));
            int pe = (p < 2) ? 2 : p;
            frame(p, 9 * pe + 1 + int'($urandom_range(0, 8)), int'($urandom_range(0, 9 * pe + 3)));
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
